alu_exec_pipe: RTL and testbench
================================

Name: alu_exec_pipe

Overview:
- Two-stage, valid/ready-handshaked ALU execute stage for the lab 5 datapath.
- Directly feeds and consumes the set-less-than function.
- Stage 1 registers the opcode and operands. Stage 2 computes and registers the result and the flags. It replaces free-running combinational comparison with a stallable, clocked pipeline.

Parameters:
- WIDTH, 32, operand and result width in bits (minimum 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream presents op/a/b this cycle.
- in_ready  output  1  stage can accept op/a/b this cycle.
- op  input  4  ALU control code.
- a  input  WIDTH  operand A (two's complement where signed).
- b  input  WIDTH  operand B.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  downstream accepts the result this cycle.
- result  output  WIDTH  ALU result.
- zero  output  1  result equals 0.
- ovf  output  1  signed overflow (ADD/SUB only).
- bad_op  output  1  op was not a defined code.

Behaviour:
- Reset: asynchronous on rst_n low.
  - s1_valid=0, s2_valid=0, out_valid=0, result=0, zero=0, ovf=0, bad_op=0.
  - in_ready follows its equation: 1 while in reset.
  - Stored op/a/b are cleared to 0.
  - Reset asserted mid-operation discards all in-flight transactions; none are emitted after release.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - result/zero/ovf/bad_op hold stable while out_valid && !out_ready.
- Ready equations (combinational):
  - s2_free = !s2_valid || out_ready.
  - s1_adv = s1_valid && s2_free.
  - in_ready = !s1_valid || s2_free.
- Stage 1:
  - On input transfer, capture op/a/b and set s1_valid=1.
  - Otherwise, if s1_adv, clear s1_valid.
  - Otherwise hold.
- Stage 2:
  - If s1_adv, load the computed result/flags from the stage-1 registers and set s2_valid=1.
  - Otherwise, if an output transfer occurs, clear s2_valid.
  - Otherwise hold.
  - out_valid = s2_valid.
- Latency and throughput:
  - Exactly 2 cycles from input transfer to out_valid when unstalled.
  - Throughput 1 per cycle with out_ready held high.
  - Simultaneous input transfer and s1_adv in the same cycle is legal and keeps the pipe full.
  - At most 2 transactions are in flight.
  - Ordering is strictly FIFO.
- Opcodes (op):
  - 0000 AND: a & b.
  - 0001 OR: a | b.
  - 0010 ADD: a + b, modulo 2^WIDTH.
  - 0110 SUB: a - b, modulo 2^WIDTH.
  - 0111 SLT: 1 if a < b signed, else 0; zero-extended to WIDTH. Equal operands give 0.
  - 1100 NOR: ~(a | b).
  - Any other code: result=0, bad_op=1.
- Flags:
  - bad_op = 0 for all defined codes.
  - zero = (result == 0), including after a bad op.
  - ovf for ADD: a and b have equal MSBs and the sum MSB differs from them.
  - ovf for SUB: a and b have different MSBs and the difference MSB differs from a's MSB.
  - ovf = 0 for all other ops.
- SLT details:
  - Must be correct across sign boundaries: compare MSBs first, then the unsigned compare of the low WIDTH-1 bits when the MSBs are equal.
  - Must not be derived from the SUB result, because that fails on overflow.
- No combinational path from op/a/b to any output.
- in_ready depends only on internal state and out_ready.

Test Plan:
1. Reset then single ops, out_ready=1.
   - SLT a=0xFFFFFFFF, b=0x00000001 -> result=1, out_valid exactly 2 cycles after accept.
   - SLT a=1, b=0xFFFFFFFF -> 0.
   - SLT a=0x7FFFFFFF, b=0x80000000 -> 0, ovf=0.
   - SLT a=5, b=5 -> 0, zero=1.
2. Arithmetic and overflow.
   - ADD 0x7FFFFFFF+1 -> 0x80000000, ovf=1.
   - SUB 0x80000000-1 -> 0x7FFFFFFF, ovf=1.
   - ADD 0xFFFFFFFF+1 -> 0, zero=1, ovf=0.
   - SUB 3-3 -> 0, zero=1.
3. Logic and illegal op.
   - AND 0xF0F0F0F0&0xFF00FF00 -> 0xF000F000.
   - OR 0x0F0F0F0F|0xF0F0F0F0 -> 0xFFFFFFFF.
   - NOR 0,0 -> 0xFFFFFFFF.
   - op=0101 -> result=0, bad_op=1, zero=1.
4. Back-to-back ADDs a=k, b=0 for k=1..8, in_valid and out_ready held 1.
   - in_ready stays 1.
   - Outputs 1..8 appear on 8 consecutive cycles, in order.
5. Backpressure.
   - out_ready=0; present ADDs with a=1, 2, 3 in consecutive cycles.
   - The first two are accepted; in_ready drops to 0 with the third held.
   - result=1 stays stable.
   - On raising out_ready, results emerge as 1, 2, 3 with no loss or duplication.
6. Reset mid-flight.
   - With 2 transactions in flight, assert rst_n=0 asynchronously between clock edges.
   - out_valid=0 immediately.
   - After release, no stale result ever appears, and the next accepted op emerges 2 cycles later.

Source files
------------

// File: rtl/alu_exec_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_pipe
// Brief    : Two-stage valid/ready ALU execute stage (operand regs -> result regs)
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             bad_op
);

  localparam logic [3:0] c_op_and = 4'b0000;
  localparam logic [3:0] c_op_or  = 4'b0001;
  localparam logic [3:0] c_op_add = 4'b0010;
  localparam logic [3:0] c_op_sub = 4'b0110;
  localparam logic [3:0] c_op_slt = 4'b0111;
  localparam logic [3:0] c_op_nor = 4'b1100;

  logic             r_s1_valid;
  logic [3:0]       r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_ovf;
  logic             r_bad_op;

  logic             w_s2_free;
  logic             w_s1_adv;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_slt;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic             w_bad;

  assign w_s2_free  = !r_s2_valid || out_ready;
  assign w_s1_adv   = r_s1_valid && w_s2_free;
  assign in_ready   = !r_s1_valid || w_s2_free;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_s2_valid && out_ready;

  assign out_valid = r_s2_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign ovf       = r_ovf;
  assign bad_op    = r_bad_op;

  assign w_sum  = r_s1_a + r_s1_b;
  assign w_diff = r_s1_a - r_s1_b;

  // Signed compare from sign bits, not from the subtraction, so overflow cannot corrupt it
  assign w_slt = (r_s1_a[WIDTH-1] != r_s1_b[WIDTH-1]) ? r_s1_a[WIDTH-1]
               : (r_s1_a[WIDTH-2:0] < r_s1_b[WIDTH-2:0]);

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_bad = 1'b0;
    case (r_s1_op)
      c_op_and: w_res = r_s1_a & r_s1_b;
      c_op_or:  w_res = r_s1_a | r_s1_b;
      c_op_add: begin
        w_res = w_sum;
        w_ovf = (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_s1_a[WIDTH-1]);
      end
      c_op_sub: begin
        w_res = w_diff;
        w_ovf = (r_s1_a[WIDTH-1] != r_s1_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_s1_a[WIDTH-1]);
      end
      c_op_slt: w_res = {{(WIDTH-1){1'b0}}, w_slt};
      c_op_nor: w_res = ~(r_s1_a | r_s1_b);
      default:  w_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else if (w_in_xfer) begin
      r_s1_valid <= 1'b1;
      r_s1_op    <= op;
      r_s1_a     <= a;
      r_s1_b     <= b;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_ovf      <= 1'b0;
      r_bad_op   <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_valid <= 1'b1;
      r_result   <= w_res;
      r_zero     <= (w_res == '0);
      r_ovf      <= w_ovf;
      r_bad_op   <= w_bad;
    end else if (w_out_xfer) begin
      r_s2_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_pipe
// Brief    : Scoreboard bench for alu_exec_pipe with directed vectors
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_pipe;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             ovf;
  logic             bad_op;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             z;
    logic             o;
    logic             bd;
    bit               lat;
    int               cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;

  alu_exec_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .ovf       (ovf),
    .bad_op    (bad_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] req);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: compares head of scoreboard whenever output is valid; pops on transfer
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        chk(1'b0, "unexpected_output", result, '0);
      end else begin
        exp_t e;
        e = sb[0];
        chk(result == e.res, "result", result, e.res);
        chk({zero, ovf, bad_op} == {e.z, e.o, e.bd}, "flags_zob",
            {29'd0, zero, ovf, bad_op}, {29'd0, e.z, e.o, e.bd});
        if (out_ready) begin
          if (e.lat) chk((cyc - e.cyc) == 2, "latency", cyc - e.cyc, 2);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [3:0] o, input logic [WIDTH-1:0] va,
                      input logic [WIDTH-1:0] vb, input logic [WIDTH-1:0] r,
                      input logic ez, input logic eo, input logic eb,
                      input bit lat, input bit chk_rdy);
    exp_t e;
    bit   done;
    int   n;
    op = o; a = va; b = vb; in_valid = 1'b1;
    done = 0; n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      if (chk_rdy && n == 0) chk(in_ready == 1'b1, "in_ready_high", in_ready, 1);
      if (in_ready) begin
        e.res = r; e.z = ez; e.o = eo; e.bd = eb; e.lat = lat; e.cyc = cyc;
        sb.push_back(e);
        done = 1;
      end
      n++;
      @(posedge clk); #1;
    end
    if (!done) chk(1'b0, "accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain;
    int n;
    n = 0;
    in_valid = 1'b0;
    while (sb.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    chk(sb.size() == 0, "drain_empty", sb.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; a = '0; b = '0;
    #12;
    chk(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
    chk(result == '0, "rst_result", result, 0);
    chk({zero, ovf, bad_op} == 3'b000, "rst_flags", {29'd0, zero, ovf, bad_op}, 0);
    chk(in_ready == 1'b1, "rst_in_ready", in_ready, 1);
    @(posedge clk); #1; rst_n = 1'b1;
    idle(2);

    // 1: SLT single ops
    send(4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'd1, 0, 0, 0, 1, 1); idle(3);
    send(4'b0111, 32'h00000001, 32'hFFFFFFFF, 32'd0, 1, 0, 0, 1, 1); idle(3);
    send(4'b0111, 32'h7FFFFFFF, 32'h80000000, 32'd0, 1, 0, 0, 1, 1); idle(3);
    send(4'b0111, 32'd5,        32'd5,        32'd0, 1, 0, 0, 1, 1); idle(3);
    send(4'b0111, 32'h80000000, 32'h00000001, 32'd1, 0, 0, 0, 1, 1); idle(3);

    // 2: arithmetic and overflow
    send(4'b0010, 32'h7FFFFFFF, 32'd1, 32'h80000000, 0, 1, 0, 1, 1); idle(3);
    send(4'b0110, 32'h80000000, 32'd1, 32'h7FFFFFFF, 0, 1, 0, 1, 1); idle(3);
    send(4'b0010, 32'hFFFFFFFF, 32'd1, 32'h00000000, 1, 0, 0, 1, 1); idle(3);
    send(4'b0110, 32'd3,        32'd3, 32'h00000000, 1, 0, 0, 1, 1); idle(3);

    // 3: logic and illegal opcode
    send(4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0, 1, 1); idle(3);
    send(4'b0001, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'hFFFFFFFF, 0, 0, 0, 1, 1); idle(3);
    send(4'b1100, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 0, 0, 0, 1, 1); idle(3);
    send(4'b0101, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1, 0, 1, 1, 1); idle(3);
    drain();

    // 4: back-to-back, full throughput
    for (int k = 1; k <= 8; k++)
      send(4'b0010, k, 32'd0, k, 0, 0, 0, 1, 1);
    drain();

    // 5: backpressure
    out_ready = 1'b0;
    send(4'b0010, 32'd1, 32'd0, 32'd1, 0, 0, 0, 0, 1);
    send(4'b0010, 32'd2, 32'd0, 32'd2, 0, 0, 0, 0, 1);
    op = 4'b0010; a = 32'd3; b = 32'd0; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk(in_ready == 1'b0, "in_ready_stalled", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(4'b0010, 32'd3, 32'd0, 32'd3, 0, 0, 0, 0, 1);
    drain();

    // 6: reset with two transactions in flight
    out_ready = 1'b0;
    send(4'b0010, 32'd10, 32'd0, 32'd10, 0, 0, 0, 0, 1);
    send(4'b0010, 32'd20, 32'd0, 32'd20, 0, 0, 0, 0, 1);
    in_valid = 1'b0;
    #2; rst_n = 1'b0;
    #1;
    chk(out_valid == 1'b0, "async_rst_out_valid", out_valid, 0);
    chk(in_ready == 1'b1, "async_rst_in_ready", in_ready, 1);
    sb.delete();
    out_ready = 1'b1;
    @(posedge clk); #1; rst_n = 1'b1;
    idle(5);
    send(4'b0000, 32'h0000FFFF, 32'h00FF00FF, 32'h000000FF, 0, 0, 0, 1, 1);
    drain();
    idle(4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
